// File: rtl/com_bus_arbiter_pkg.sv
// Shared definitions for the common snoop-bus arbiter and the cache wrappers
// around it. Holds the bus geometry defaults and the arbiter state encoding.
package com_bus_arbiter_pkg;

  localparam int ADDRESSSIZE      = 32;
  localparam int ASSOCIATIVITY    = 4;

  // 4 cores x (I-cache + D-cache) wrappers share the bus.
  localparam int NUM_REQ_DEFAULT  = 8;
  // Longest uninterrupted tenure before a holder is forced off the bus.
  localparam int MAX_HOLD_DEFAULT = 64;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/com_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin pick.
// Ports:
//   req_i        : request vector, one bit per requester
//   last_owner_i : index of the most recent bus owner (lowest priority)
//   winner_o     : one-hot winner, zero when nobody requests
//   valid_o      : high when winner_o has a bit set
module rr_priority_pick
  import com_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     last_owner_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic               valid_o
);

  logic [IDW-1:0] idx;

  // Walk the requesters starting just after last_owner, wrapping at NUM_REQ,
  // and keep the first one found. last_owner itself is visited last.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = last_owner_i;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + IDW'(1);
      if (!valid_o && req_i[idx]) begin
        valid_o       = 1'b1;
        winner_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/com_bus_arbiter.sv
// Arbiter for the common snoop bus shared by all cache wrappers.
// Round-robin, non-preemptive, with a hold limit and a mandatory one-cycle
// turnaround (all grants low) between any two tenures.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   Com_Bus_Req_proc  : per-requester request (level, held until granted)
//   Com_Bus_Gnt_proc  : registered one-hot grant (or zero)
//   Gnt_id            : index of current holder, 0 when idle
//   Bus_busy          : any grant asserted
//   Hold_timeout      : one-cycle pulse (during the turnaround) after a
//                       holder was forced off at MAX_HOLD cycles
module com_bus_arbiter
  import com_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] Com_Bus_Req_proc,
  output logic [NUM_REQ-1:0] Com_Bus_Gnt_proc,
  output logic [IDW-1:0]     Gnt_id,
  output logic               Bus_busy,
  output logic               Hold_timeout
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  // Low for the first edge after reset release so no grant can be issued
  // on that edge.
  logic               arm_q;

  logic [NUM_REQ-1:0] win_oh;
  logic               win_valid;
  logic [IDW-1:0]     win_id;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req_i        (Com_Bus_Req_proc),
    .last_owner_i (owner_q),
    .winner_o     (win_oh),
    .valid_o      (win_valid)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_id = IDW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    owner_d   = owner_q;
    cnt_d     = '0;
    timeout_d = 1'b0;
    unique case (state_q)
      // The turnaround cycle arbitrates exactly like idle; what makes it a
      // turnaround is that its own grant output is already zero.
      ARB_IDLE, ARB_TURN: begin
        state_d  = ARB_IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        if (arm_q && win_valid) begin
          state_d  = ARB_GRANT;
          gnt_d    = win_oh;
          gnt_id_d = win_id;
        end
      end
      ARB_GRANT: begin
        cnt_d = (cnt_q == CW'(MAX_HOLD)) ? cnt_q : cnt_q + CW'(1);
        // cnt_d counts the current grant cycle, so a release at MAX_HOLD
        // leaves the grant visible for exactly MAX_HOLD cycles.
        if (!Com_Bus_Req_proc[gnt_id_q] || cnt_d == CW'(MAX_HOLD)) begin
          timeout_d = Com_Bus_Req_proc[gnt_id_q];
          state_d   = ARB_TURN;
          gnt_d     = '0;
          gnt_id_d  = '0;
          owner_d   = gnt_id_q;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      owner_q   <= IDW'(NUM_REQ - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      arm_q     <= 1'b1;
    end
  end

  assign Com_Bus_Gnt_proc = gnt_q;
  assign Gnt_id           = gnt_id_q;
  assign Bus_busy         = |gnt_q;
  assign Hold_timeout     = timeout_q;

endmodule
